forward_scoreboard: RTL and testbench

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

---
 rtl/fwd_pkg.sv | 19 +
 rtl/fwd_match.sv | 35 +++
 rtl/forward_scoreboard.sv | 96 +++++++++
 tb/tb_forward_scoreboard.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared definitions for the operand-forwarding scoreboard.
package fwd_pkg;

    // Select code meaning "read the register file, no bypass".
    localparam int unsigned SEL_REGFILE = 0;

    // Stall-cycle counter width and its saturation value.
    localparam int unsigned CNT_W   = 16;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Per-entry control flags. The destination address is kept alongside,
    // in a separate vector, because its width is a module parameter.
    typedef struct packed {
        logic valid;
        logic regwrite;
        logic load;
    } ent_flags_t;

endpackage

// File: rtl/fwd_match.sv
// Priority match of one source operand against all in-flight producers.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned SEL_W    = 2
) (
    input  ent_flags_t [DEPTH-1:0]        ent_flags_i,
    input  logic       [DEPTH*ADDR_W-1:0] ent_rd_i,
    input  logic       [ADDR_W-1:0]       src_addr_i,
    output logic       [SEL_W-1:0]        sel_o,
    output logic                          load_hit_o
);

    logic found;

    // Youngest matching producer wins; $0 never matches because rd must be nonzero.
    always_comb begin
        sel_o      = SEL_W'(SEL_REGFILE);
        load_hit_o = 1'b0;
        found      = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!found && ent_flags_i[k].valid && ent_flags_i[k].regwrite &&
                (ent_rd_i[k*ADDR_W +: ADDR_W] != '0) &&
                (ent_rd_i[k*ADDR_W +: ADDR_W] == src_addr_i)) begin
                found      = 1'b1;
                sel_o      = SEL_W'(k + 1);
                load_hit_o = ent_flags_i[k].load && (k < LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// Tracks in-flight producers, selects bypass sources and requests load-use stalls.
module forward_scoreboard
    import fwd_pkg::*;
#(
    parameter  int unsigned NUM_SRC  = 2,
    parameter  int unsigned DEPTH    = 2,
    parameter  int unsigned LOAD_LAT = 1,
    parameter  int unsigned ADDR_W   = 5,
    localparam int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cons_valid_i,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0]         cons_rd_i,
    input  logic                      cons_regwrite_i,
    input  logic                      cons_load_i,
    input  logic                      hold_i,
    input  logic                      flush_i,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
    output logic                      stall_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    ent_flags_t [DEPTH-1:0]        flags_q, flags_d;
    logic       [DEPTH*ADDR_W-1:0] rd_q, rd_d;
    logic       [CNT_W-1:0]        cnt_q, cnt_d;
    logic       [NUM_SRC-1:0]      load_hit;
    logic                          stall;
    logic                          push;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_port
        fwd_match #(
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .ADDR_W   (ADDR_W),
            .SEL_W    (SEL_W)
        ) u_match (
            .ent_flags_i (flags_q),
            .ent_rd_i    (rd_q),
            .src_addr_i  (src_addr_i[s*ADDR_W +: ADDR_W]),
            .sel_o       (fwd_sel_o[s*SEL_W +: SEL_W]),
            .load_hit_o  (load_hit[s])
        );
    end

    // Stall on an unready load result; a flush overrides both stall and push.
    always_comb begin
        stall = cons_valid_i & ~flush_i & (|load_hit);
        push  = cons_valid_i & ~stall & ~flush_i;
    end

    // Shift the producer window one stage and insert the consumer or a bubble.
    always_comb begin
        flags_d = flags_q;
        rd_d    = rd_q;
        if (!hold_i) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                flags_d[k]                = flags_q[k-1];
                rd_d[k*ADDR_W +: ADDR_W]  = rd_q[(k-1)*ADDR_W +: ADDR_W];
            end
            flags_d[0].valid    = push;
            flags_d[0].regwrite = push & cons_regwrite_i;
            flags_d[0].load     = push & cons_load_i;
            rd_d[ADDR_W-1:0]    = push ? cons_rd_i : '0;
        end
    end

    // Count advancing stall cycles, saturating at the top value.
    always_comb begin
        cnt_d = cnt_q;
        if (!hold_i && stall && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flags_q <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            flags_q <= flags_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Drive outputs.
    always_comb begin
        stall_o     = stall;
        stall_cnt_o = cnt_q;
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard: default instance plus a deep
// instance used to reach counter saturation in a reasonable cycle count.
module tb_forward_scoreboard;

    logic        clk;
    logic        rst;
    int          vectors;
    int          miscompares;

    // Default instance (NUM_SRC=2, DEPTH=2, LOAD_LAT=1)
    logic        cons_valid;
    logic [9:0]  src_addr;
    logic [4:0]  cons_rd;
    logic        cons_rw;
    logic        cons_ld;
    logic        hold;
    logic        flush;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [15:0] stall_cnt;

    // Deep instance (NUM_SRC=1, DEPTH=7, LOAD_LAT=7)
    logic        cons2_valid;
    logic [4:0]  src2_addr;
    logic [4:0]  cons2_rd;
    logic        cons2_rw;
    logic        cons2_ld;
    logic [2:0]  fwd2_sel;
    logic        stall2;
    logic [15:0] stall2_cnt;

    forward_scoreboard #(
        .NUM_SRC  (2),
        .DEPTH    (2),
        .LOAD_LAT (1),
        .ADDR_W   (5)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cons_valid_i    (cons_valid),
        .src_addr_i      (src_addr),
        .cons_rd_i       (cons_rd),
        .cons_regwrite_i (cons_rw),
        .cons_load_i     (cons_ld),
        .hold_i          (hold),
        .flush_i         (flush),
        .fwd_sel_o       (fwd_sel),
        .stall_o         (stall),
        .stall_cnt_o     (stall_cnt)
    );

    forward_scoreboard #(
        .NUM_SRC  (1),
        .DEPTH    (7),
        .LOAD_LAT (7),
        .ADDR_W   (5)
    ) dut2 (
        .clk_i           (clk),
        .rst_i           (rst),
        .cons_valid_i    (cons2_valid),
        .src_addr_i      (src2_addr),
        .cons_rd_i       (cons2_rd),
        .cons_regwrite_i (cons2_rw),
        .cons_load_i     (cons2_ld),
        .hold_i          (1'b0),
        .flush_i         (1'b0),
        .fwd_sel_o       (fwd2_sel),
        .stall_o         (stall2),
        .stall_cnt_o     (stall2_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive the default instance's consumer: valid, src1, src0, rd, regwrite, load.
    task automatic cons(input logic v, input logic [4:0] s1, input logic [4:0] s0,
                        input logic [4:0] rd, input logic rw, input logic ld);
        cons_valid = v;
        src_addr   = {s1, s0};
        cons_rd    = rd;
        cons_rw    = rw;
        cons_ld    = ld;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        hold        = 1'b0;
        flush       = 1'b0;
        cons_valid  = 1'b0;
        src_addr    = '0;
        cons_rd     = '0;
        cons_rw     = 1'b0;
        cons_ld     = 1'b0;
        cons2_valid = 1'b0;
        src2_addr   = '0;
        cons2_rd    = '0;
        cons2_rw    = 1'b0;
        cons2_ld    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        cons(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("reset_sel", 32'(fwd_sel), 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_cnt", 32'(stall_cnt), 32'h0);

        // ALU producer $3, then EX/MEM bypass, then MEM/WB bypass
        cons(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        tick();
        cons(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0);
        chk("alu_sel0_stage0", 32'(fwd_sel), 32'h1);
        chk("alu_no_stall", 32'(stall), 32'h0);
        tick();
        cons(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("alu_sel1_stage1", 32'(fwd_sel), 32'h8);
        tick();

        // Load $5 followed immediately by a use: one stall cycle
        cons(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
        tick();
        cons(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
        chk("loaduse_stall", 32'(stall), 32'h1);
        chk("loaduse_sel_during", 32'(fwd_sel), 32'h4);
        tick();
        chk("loaduse_sel_after", 32'(fwd_sel), 32'h8);
        chk("loaduse_stall_after", 32'(stall), 32'h0);
        chk("loaduse_cnt", 32'(stall_cnt), 32'h1);
        tick();

        // Producer writing $0 is never forwarded, even as a load
        cons(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        cons(1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("zero_reg_sel", 32'(fwd_sel), 32'h8);
        chk("zero_reg_stall", 32'(stall), 32'h0);
        tick();

        // Two producers of $7: youngest wins on both ports
        cons(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        tick();
        tick();
        cons(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0);
        chk("dup_youngest", 32'(fwd_sel), 32'h5);
        tick();
        cons(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
        chk("dup_older_left", 32'(fwd_sel), 32'h2);
        tick();

        // Flush beats a load-use stall and inserts a bubble
        cons(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
        tick();
        flush = 1'b1;
        cons(1'b1, 5'd0, 5'd9, 5'd10, 1'b1, 1'b0);
        chk("flush_no_stall", 32'(stall), 32'h0);
        chk("flush_sel", 32'(fwd_sel), 32'h1);
        tick();
        flush = 1'b0;
        cons(1'b1, 5'd10, 5'd9, 5'd0, 1'b0, 1'b0);
        chk("flush_bubble_sel", 32'(fwd_sel), 32'h2);
        chk("flush_after_stall", 32'(stall), 32'h0);
        tick();

        // Hold during a stall freezes state; reset then clears it
        cons(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b1);
        tick();
        cons(1'b1, 5'd0, 5'd11, 5'd0, 1'b0, 1'b0);
        chk("hold_pre_stall", 32'(stall), 32'h1);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_stall", 32'(stall), 32'h1);
            chk("hold_sel", 32'(fwd_sel), 32'h1);
            chk("hold_cnt", 32'(stall_cnt), 32'h1);
        end
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        hold = 1'b0;
        #1;
        chk("rst_midstall_stall", 32'(stall), 32'h0);
        chk("rst_midstall_sel", 32'(fwd_sel), 32'h0);
        chk("rst_midstall_cnt", 32'(stall_cnt), 32'h0);
        cons(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        // Saturation on the deep instance: one load push then seven stall cycles per round
        for (int r = 0; r < 9363; r++) begin
            cons2_valid = 1'b1;
            src2_addr   = 5'd0;
            cons2_rd    = 5'd12;
            cons2_rw    = 1'b1;
            cons2_ld    = 1'b1;
            tick();
            src2_addr = 5'd12;
            cons2_rd  = 5'd0;
            cons2_rw  = 1'b0;
            cons2_ld  = 1'b0;
            #1;
            if (r == 0) begin
                chk("deep_stall", 32'(stall2), 32'h1);
                chk("deep_sel", 32'(fwd2_sel), 32'h1);
            end
            for (int j = 0; j < 7; j++) begin
                tick();
            end
            if (r == 0) begin
                chk("deep_cnt_round1", 32'(stall2_cnt), 32'h7);
                chk("deep_stall_drained", 32'(stall2), 32'h0);
            end
            if (r == 9361) begin
                chk("deep_cnt_near_max", 32'(stall2_cnt), 32'hFFFE);
            end
        end
        chk("deep_cnt_saturated", 32'(stall2_cnt), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
